// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM read/write arbiter: response-state encoding and
// the width helper for the write-starvation counter.
// No ports; imported by the arbiter top and the read-response holding stage.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,   // no read response outstanding
      INFLIGHT = 2'd1,   // read issued last cycle, data comes straight from the macro
      HELD     = 2'd2    // response stalled, data parked in hold_q
   } resp_st_e;

   // Counter width able to represent 0..max_cnt inclusive.
   function automatic int starve_w(input int max_cnt);
      return $clog2(max_cnt + 1);
   endfunction

endpackage

// File: rtl/sram_rw_arbiter_if.sv
// Bundle of requester handshakes and macro RW0 signals around the arbiter.
// slave: arbiter view (takes requests, drives the macro, returns read data).
// master: environment view (requesters, response sink and the SRAM macro).
interface sram_rw_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 48,
   parameter int MASK_W = 8
);
   logic              rd_req_valid;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_req_addr;
   logic              rd_resp_valid;
   logic              rd_resp_ready;
   logic [DATA_W-1:0] rd_resp_data;
   logic              wr_req_valid;
   logic              wr_req_ready;
   logic [ADDR_W-1:0] wr_req_addr;
   logic [DATA_W-1:0] wr_req_data;
   logic [MASK_W-1:0] wr_req_mask;
   logic              sram_en;
   logic              sram_wmode;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [MASK_W-1:0] sram_wmask;
   logic [DATA_W-1:0] sram_rdata;

   modport slave (
      input  rd_req_valid, rd_req_addr, rd_resp_ready,
      input  wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
      input  sram_rdata,
      output rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
      output sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask
   );

   modport master (
      output rd_req_valid, rd_req_addr, rd_resp_ready,
      output wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
      output sram_rdata,
      input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
      input  sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask
   );
endinterface

// File: rtl/sram_rd_resp_hold.sv
// Read-response stage: absorbs the macro's 1-cycle read latency and parks data when stalled.
// Latency: response valid the cycle after rd_issue, data passed through from sram_rdata.
// Backpressure: on !rd_resp_ready the data is captured into hold_q; rd_ok drops until accepted.
// Ports: clock/reset, rd_issue (read granted this cycle), rd_resp_ready, sram_rdata in;
//        rd_ok, rd_resp_valid, rd_resp_data out.
module sram_rd_resp_hold
   import sram_arb_pkg::*;
#(
   parameter int DATA_W = 48
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_issue,
   input  logic              rd_resp_ready,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              rd_ok,
   output logic              rd_resp_valid,
   output logic [DATA_W-1:0] rd_resp_data
);

   resp_st_e          resp_st_q, resp_st_d;
   logic [DATA_W-1:0] hold_q, hold_d;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         resp_st_q <= IDLE;
         hold_q    <= '0;
      end else begin
         resp_st_q <= resp_st_d;
         hold_q    <= hold_d;
      end
   end

   // Next state
   always_comb begin
      resp_st_d = resp_st_q;
      hold_d    = hold_q;
      case (resp_st_q)
         IDLE: begin
            if (rd_issue) resp_st_d = INFLIGHT;
         end
         INFLIGHT: begin
            // Macro output is only valid this one cycle, so park it if not taken.
            if (!rd_resp_ready) begin
               resp_st_d = HELD;
               hold_d    = sram_rdata;
            end else begin
               resp_st_d = rd_issue ? INFLIGHT : IDLE;
            end
         end
         HELD: begin
            if (rd_resp_ready) resp_st_d = rd_issue ? INFLIGHT : IDLE;
         end
         default: resp_st_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      // A slot frees up in the same cycle the current response is accepted.
      rd_ok         = (resp_st_q == IDLE) || rd_resp_ready;
      // Reset is synchronous, so mask the stale state during the reset cycle itself.
      rd_resp_valid = (resp_st_q != IDLE) && !reset;
      rd_resp_data  = (resp_st_q == HELD) ? hold_q : sram_rdata;
   end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Arbitrates one reader and one writer onto a single-port byte-masked SRAM RW0 port.
// Latency: grant is combinational in the request cycle; read data returns one cycle later.
// Backpressure: reads stall while a response is unaccepted; writes win after WR_STARVE_MAX lost conflicts.
// Ports: clock, reset (sync, active-high), bus (slave view: request/response handshakes and macro pins).
module sram_rw_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 48,
   parameter int MASK_W        = 8,
   parameter int WR_STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   sram_rw_arbiter_if.slave  bus
);

   localparam int STARVE_W = starve_w(WR_STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rd_ok, rd_elig, wr_elig, starved, rd_gnt, wr_gnt;
   logic                sram_en, sram_wmode;
   logic [MASK_W-1:0]   sram_wmask;

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt_q <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   // Grant and starvation counter
   always_comb begin
      rd_elig = !reset && bus.rd_req_valid && rd_ok;
      wr_elig = !reset && bus.wr_req_valid;
      starved = (starve_cnt_q == STARVE_W'(WR_STARVE_MAX));
      rd_gnt  = rd_elig && !(wr_elig && starved);
      wr_gnt  = wr_elig && !rd_gnt;

      starve_cnt_d = starve_cnt_q;
      if (!bus.wr_req_valid || wr_gnt)
         starve_cnt_d = '0;
      else if (rd_gnt && !starved)
         starve_cnt_d = starve_cnt_q + STARVE_W'(1);
   end

   // Macro drive. Address and write data only move on an actual access so the
   // macro pins stay quiet in idle cycles.
   always_comb begin
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_wmask = '0;
      if (rd_gnt) begin
         sram_en = 1'b1;
         addr_d  = bus.rd_req_addr;
      end else if (wr_gnt && (|bus.wr_req_mask)) begin
         // A zero-mask write is still handshaked but never touches the macro.
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_wmask = bus.wr_req_mask;
         addr_d     = bus.wr_req_addr;
         wdata_d    = bus.wr_req_data;
      end
   end

   assign bus.rd_req_ready = rd_gnt;
   assign bus.wr_req_ready = wr_gnt;
   assign bus.sram_en      = sram_en;
   assign bus.sram_wmode   = sram_wmode;
   assign bus.sram_wmask   = sram_wmask;
   assign bus.sram_addr    = addr_d;
   assign bus.sram_wdata   = wdata_d;

   sram_rd_resp_hold #(.DATA_W(DATA_W)) u_hold (
      .clock        (clock),
      .reset        (reset),
      .rd_issue     (rd_gnt),
      .rd_resp_ready(bus.rd_resp_ready),
      .sram_rdata   (bus.sram_rdata),
      .rd_ok        (rd_ok),
      .rd_resp_valid(bus.rd_resp_valid),
      .rd_resp_data (bus.rd_resp_data)
   );

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: behavioural 256x48 byte-masked SRAM macro, a
// table of per-cycle vectors, then hand-written back-pressure, starvation,
// streaming and reset-mid-read sequences.
module tb_sram_rw_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 48;
   localparam int MASK_W = 8;
   localparam int SEG_W  = DATA_W / MASK_W;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   sram_rw_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

   sram_rw_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .WR_STARVE_MAX(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Macro model: one-cycle read latency, output register holds between reads.
   logic [DATA_W-1:0] mem [256];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] wword;
   always @(posedge clock) begin
      if (bus.sram_en) begin
         if (bus.sram_wmode) begin
            wword = mem[bus.sram_addr];
            for (int s = 0; s < MASK_W; s++)
               if (bus.sram_wmask[s]) wword[s*SEG_W +: SEG_W] = bus.sram_wdata[s*SEG_W +: SEG_W];
            mem[bus.sram_addr] <= wword;
         end else begin
            rdata_q <= mem[bus.sram_addr];
         end
      end
   end
   assign bus.sram_rdata = rdata_q;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rv, input logic [7:0] ra, input logic wv, input logic [7:0] wa,
                        input logic [47:0] wd, input logic [7:0] wm, input logic rr);
      bus.rd_req_valid  = rv;
      bus.rd_req_addr   = ra;
      bus.wr_req_valid  = wv;
      bus.wr_req_addr   = wa;
      bus.wr_req_data   = wd;
      bus.wr_req_mask   = wm;
      bus.rd_resp_ready = rr;
   endtask

   task automatic next_cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   typedef struct {
      logic        rv;
      logic [7:0]  ra;
      logic        wv;
      logic [7:0]  wa;
      logic [47:0] wd;
      logic [7:0]  wm;
      logic        rr;
      logic        e_rrdy;
      logic        e_wrdy;
      logic        e_en;
      logic        e_wmode;
      logic        e_rvld;
      logic        e_chkd;
      logic [47:0] e_data;
   } vec_t;

   vec_t vecs [14];

   logic [47:0] exp_a, exp_b, exp_c, sdata;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //            rv ra     wv wa     wd                wm     rr  rrdy wrdy en wm rvld chk data
      vecs[0]  = '{1'b0, 8'h00, 1'b1, 8'h10, 48'hABCDEF012345, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 48'h0};
      vecs[1]  = '{1'b1, 8'h10, 1'b0, 8'h00, 48'h0,            8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 48'h0,            8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 48'hABCDEF012345};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'h20, 48'hFFFFFFFFFFFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 48'h0};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h20, 48'h000000000000, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 48'h0};
      vecs[5]  = '{1'b1, 8'h20, 1'b0, 8'h00, 48'h0,            8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 48'h0,            8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 48'hFFFFFFFFFFC0};
      // zero-mask write: handshaked, macro untouched
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h10, 48'h000000000000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0};
      // conflict, read wins at starve_cnt 0
      vecs[8]  = '{1'b1, 8'h10, 1'b1, 8'h40, 48'h00000000DEAD, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h40, 48'h00000000DEAD, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 48'hABCDEF012345};
      // same-address conflict: read wins and sees pre-write data
      vecs[10] = '{1'b1, 8'h40, 1'b1, 8'h40, 48'h111111111111, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h40, 48'h111111111111, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 48'h00000000DEAD};
      vecs[12] = '{1'b1, 8'h40, 1'b0, 8'h00, 48'h0,            8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 48'h0,            8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 48'h111111111111};

      // ---- reset state, with both requests asserted ----
      reset = 1'b1;
      drive(1'b1, 8'h10, 1'b1, 8'h10, 48'h0, 8'hFF, 1'b1);
      repeat (3) next_cyc();
      mid();
      chkw("rst_rd_rdy",   64'(bus.rd_req_ready),      64'd0);
      chkw("rst_wr_rdy",   64'(bus.wr_req_ready),      64'd0);
      chkw("rst_sram_en",  64'(bus.sram_en),           64'd0);
      chkw("rst_resp_vld", 64'(bus.rd_resp_valid),     64'd0);
      chkw("rst_starve",   64'(dut.starve_cnt_q),      64'd0);
      chkw("rst_hold",     64'(dut.u_hold.hold_q),     64'd0);
      chkw("rst_resp_st",  64'(dut.u_hold.resp_st_q),  64'd0);
      next_cyc();
      reset = 1'b0;

      // ---- table-driven vectors, one row per cycle ----
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rv, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].wm, vecs[i].rr);
         mid();
         chkw($sformatf("v%0d_rd_rdy", i),   64'(bus.rd_req_ready),  64'(vecs[i].e_rrdy));
         chkw($sformatf("v%0d_wr_rdy", i),   64'(bus.wr_req_ready),  64'(vecs[i].e_wrdy));
         chkw($sformatf("v%0d_sram_en", i),  64'(bus.sram_en),       64'(vecs[i].e_en));
         chkw($sformatf("v%0d_resp_vld", i), 64'(bus.rd_resp_valid), 64'(vecs[i].e_rvld));
         if (vecs[i].e_en) begin
            chkw($sformatf("v%0d_wmode", i), 64'(bus.sram_wmode), 64'(vecs[i].e_wmode));
            chkw($sformatf("v%0d_addr", i),  64'(bus.sram_addr),
                 64'(vecs[i].e_rrdy ? vecs[i].ra : vecs[i].wa));
            chkw($sformatf("v%0d_wmask", i), 64'(bus.sram_wmask),
                 64'(vecs[i].e_wmode ? vecs[i].wm : 8'h00));
         end
         if (vecs[i].e_chkd)
            chkw($sformatf("v%0d_resp_data", i), 64'(bus.rd_resp_data), 64'(vecs[i].e_data));
         next_cyc();
      end

      // ---- back-pressure: held data stable while 0x30 is overwritten ----
      exp_a = 48'h0A0A0A0A0A0A;
      exp_b = 48'h0B0B0B0B0B0B;
      drive(1'b0, 8'h00, 1'b1, 8'h30, exp_a, 8'hFF, 1'b1);
      mid(); chkw("bp_wr_a_rdy", 64'(bus.wr_req_ready), 64'd1);
      next_cyc();
      drive(1'b1, 8'h30, 1'b0, 8'h00, 48'h0, 8'h00, 1'b0);
      mid(); chkw("bp_rd_rdy", 64'(bus.rd_req_ready), 64'd1);
      next_cyc();
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 8'h30, (c == 0), 8'h30, exp_b, 8'hFF, 1'b0);
         mid();
         chkw($sformatf("bp%0d_vld", c),    64'(bus.rd_resp_valid), 64'd1);
         chkw($sformatf("bp%0d_data", c),   64'(bus.rd_resp_data),  64'(exp_a));
         chkw($sformatf("bp%0d_rd_rdy", c), 64'(bus.rd_req_ready),  64'd0);
         if (c == 0) chkw("bp_wr_b_rdy", 64'(bus.wr_req_ready), 64'd1);
         next_cyc();
      end
      drive(1'b1, 8'h30, 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
      mid();
      chkw("bp_acc_data",   64'(bus.rd_resp_data),  64'(exp_a));
      chkw("bp_acc_rd_rdy", 64'(bus.rd_req_ready),  64'd1);
      next_cyc();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
      mid();
      chkw("bp_new_vld",  64'(bus.rd_resp_valid), 64'd1);
      chkw("bp_new_data", 64'(bus.rd_resp_data),  64'(exp_b));
      next_cyc();
      mid(); chkw("bp_idle_vld", 64'(bus.rd_resp_valid), 64'd0);
      next_cyc();

      // ---- starvation: write wins on the 5th conflict cycle ----
      exp_c = 48'h0C0C0C0C0C0C;
      drive(1'b1, 8'h30, 1'b1, 8'h50, exp_c, 8'hFF, 1'b1);
      for (int c = 0; c < 4; c++) begin
         mid();
         chkw($sformatf("st%0d_wr_rdy", c), 64'(bus.wr_req_ready), 64'd0);
         chkw($sformatf("st%0d_rd_rdy", c), 64'(bus.rd_req_ready), 64'd1);
         chkw($sformatf("st%0d_cnt", c),    64'(dut.starve_cnt_q), 64'(c));
         next_cyc();
      end
      mid();
      chkw("st4_wr_rdy", 64'(bus.wr_req_ready), 64'd1);
      chkw("st4_rd_rdy", 64'(bus.rd_req_ready), 64'd0);
      chkw("st4_cnt",    64'(dut.starve_cnt_q), 64'd4);
      next_cyc();
      drive(1'b1, 8'h50, 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
      mid();
      chkw("st_cnt_clr", 64'(dut.starve_cnt_q), 64'd0);
      chkw("st_rd_rdy",  64'(bus.rd_req_ready), 64'd1);
      next_cyc();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
      mid(); chkw("st_wr_data", 64'(bus.rd_resp_data), 64'(exp_c));
      next_cyc();

      // ---- streaming: 16 back-to-back reads ----
      for (int i = 0; i < 16; i++) begin
         sdata = {40'h5A5A5A5A5A, 8'(i * 17)};
         drive(1'b0, 8'h00, 1'b1, 8'(8'h60 + i), sdata, 8'hFF, 1'b1);
         mid(); chkw($sformatf("sw%0d_wr_rdy", i), 64'(bus.wr_req_ready), 64'd1);
         next_cyc();
      end
      for (int i = 0; i <= 16; i++) begin
         drive(i < 16, 8'(8'h60 + i), 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
         mid();
         if (i < 16) chkw($sformatf("sr%0d_rd_rdy", i), 64'(bus.rd_req_ready), 64'd1);
         if (i > 0) begin
            sdata = {40'h5A5A5A5A5A, 8'((i - 1) * 17)};
            chkw($sformatf("sr%0d_vld", i),  64'(bus.rd_resp_valid), 64'd1);
            chkw($sformatf("sr%0d_data", i), 64'(bus.rd_resp_data),  64'(sdata));
         end
         next_cyc();
      end
      mid(); chkw("sr_end_vld", 64'(bus.rd_resp_valid), 64'd0);
      next_cyc();

      // ---- reset during the INFLIGHT cycle ----
      drive(1'b1, 8'h60, 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
      mid(); chkw("rm_rd_rdy", 64'(bus.rd_req_ready), 64'd1);
      next_cyc();
      reset = 1'b1;
      drive(1'b1, 8'h61, 1'b1, 8'h61, 48'h0, 8'hFF, 1'b1);
      mid();
      chkw("rm_rst_vld",    64'(bus.rd_resp_valid), 64'd0);
      chkw("rm_rst_rd_rdy", 64'(bus.rd_req_ready),  64'd0);
      chkw("rm_rst_wr_rdy", 64'(bus.wr_req_ready),  64'd0);
      chkw("rm_rst_en",     64'(bus.sram_en),       64'd0);
      next_cyc();
      reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
      mid(); chkw("rm_post_vld0", 64'(bus.rd_resp_valid), 64'd0);
      next_cyc();
      mid(); chkw("rm_post_vld1", 64'(bus.rd_resp_valid), 64'd0);
      next_cyc();
      drive(1'b1, 8'h10, 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
      mid(); chkw("rm_regrant", 64'(bus.rd_req_ready), 64'd1);
      next_cyc();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 48'h0, 8'h00, 1'b1);
      mid();
      chkw("rm_regrant_vld",  64'(bus.rd_resp_valid), 64'd1);
      chkw("rm_regrant_data", 64'(bus.rd_resp_data),  64'(48'hABCDEF012345));
      next_cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Arbitrates one read requester and one write requester onto a single-port, 256×48, 8-segment byte-masked SRAM macro (6-bit mask granule). It sits between the requesters and the macro's RW0 port and owns all `RW0_en`/`RW0_wmode` sequencing. It absorbs the macro's one-cycle read latency and provides back-pressured read responses with held data. Write starvation under continuous reads is bounded by a counter.

## Interface
- `ADDR_W`, default 8: SRAM address width.
- `DATA_W`, default 48: SRAM data width.
- `MASK_W`, default 8: write-mask segments; `DATA_W/MASK_W` bits per segment.
- `WR_STARVE_MAX`, default 4: maximum consecutive lost conflicts for a pending write.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rd_req_valid` / `rd_req_ready`  in / out  1 / 1  read request handshake.
- `rd_req_addr`  in  ADDR_W  read address.
- `rd_resp_valid` / `rd_resp_ready`  out / in  1 / 1  read response handshake.
- `rd_resp_data`  out  DATA_W  read data.
- `wr_req_valid` / `wr_req_ready`  in / out  1 / 1  write request handshake.
- `wr_req_addr`, `wr_req_data`, `wr_req_mask`  in  ADDR_W, DATA_W, MASK_W  write request payload.
- `sram_en`, `sram_wmode`  out  1, 1  to macro `RW0_en`, `RW0_wmode`.
- `sram_addr`, `sram_wdata`, `sram_wmask`  out  ADDR_W, DATA_W, MASK_W  to macro.
- `sram_rdata`  in  DATA_W  from macro; valid the cycle after a read issues.

## Operation
- Response state machine, `resp_st`:
  - IDLE: no response outstanding.
  - INFLIGHT: read issued last cycle; `rd_resp_data = sram_rdata`.
  - HELD: data captured in `hold_q`; `rd_resp_data = hold_q`.
- `rd_resp_valid = (resp_st != IDLE)`.
- Transitions:
  - INFLIGHT and not `rd_resp_ready`: capture `sram_rdata` into `hold_q`, go to HELD.
  - INFLIGHT or HELD, response accepted: go to INFLIGHT if a new read issues this cycle, else IDLE.
  - IDLE: go to INFLIGHT on read issue.
- `rd_ok = (resp_st == IDLE) || rd_resp_ready`, so back-to-back reads run at full throughput.
- Grant, evaluated each cycle:
  - Only one request eligible (read needs `rd_req_valid && rd_ok`): it wins.
  - Both eligible: read wins unless `starve_cnt == WR_STARVE_MAX`, then write wins.
- `starve_cnt`:
  - Increments, saturating, when a write is pending and the read wins the conflict.
  - Clears on write grant or when `wr_req_valid` is low.
- `rd_req_ready` and `wr_req_ready` are combinational grant outputs; at most one is high per cycle.
- Read grant drives: `sram_en=1`, `sram_wmode=0`, `sram_addr=rd_req_addr`, `sram_wmask=0`.
- Write grant drives: `sram_en=1`, `sram_wmode=1`, addr/data/mask from the write request.
- Zero-mask write: accepted in its grant cycle; `sram_en` stays 0.
- No grant: `sram_en=0`; `sram_addr`/`sram_wdata` hold their last values (no toggling).
- Ordering:
  - A same-cycle read and write conflict to one address returns pre-write data when the read wins.
  - A read issued in any cycle after a write grant sees the written data.

## Timing
- Read latency: request handshake in cycle T, `rd_resp_valid` in T+1 with `sram_rdata` passed through.
- Held data stays stable until accepted, even if a write to the same address lands meanwhile.
- Write completes at the edge ending its grant cycle.
- While `reset` is high: all readies 0, `sram_en=0`, `rd_resp_valid=0`; `resp_st=IDLE`, `starve_cnt=0`, `hold_q=0`.
- Reset asserted mid-operation drops an in-flight read response; no response is produced after reset.
- First grant can occur in the cycle after `reset` deasserts.

## Structure
- Package `sram_arb_pkg`: `resp_st_e` enum {IDLE, INFLIGHT, HELD} and a `STARVE_W = $clog2(WR_STARVE_MAX+1)` helper function.
- Sub-module `sram_rd_resp_hold`: owns `resp_st`, `hold_q` and the response mux, and exports `rd_ok`.
- Grant logic and `starve_cnt` live in the top module.

## Test plan
- Single read: write addr 0x10 data 0xABCDEF012345 with mask 0xFF, then read 0x10 → `rd_resp_valid` one cycle after handshake, data 0xABCDEF012345.
- Masked write: preload 0x20 with all-ones, write 0x000000000000 with mask 0x01 → readback 0xFFFFFFFFFFC0.
- Back-pressure: hold `rd_resp_ready=0` for 5 cycles after a read of 0x30, write 0x30 meanwhile → `rd_resp_data` stays the old value throughout; `rd_req_ready=0` until accepted.
- Starvation: continuous reads plus a pending write with `WR_STARVE_MAX=4` → write granted on the 5th conflict cycle; `starve_cnt` returns to 0.
- Streaming: 16 back-to-back reads with `rd_resp_ready=1` → 16 responses on consecutive cycles, in order.
- Reset mid-read: assert `reset` in the INFLIGHT cycle → `rd_resp_valid=0` the next cycle; no stray response after release.
